alu_op_sequencer: RTL and testbench

- Initiator side of the ALU functional-unit enable interface.
- Accepts an opcode plus two operands over a valid/ready request channel and drives the one-hot enable for the matching unit (AND, OR, XOR, ...).
- Waits a fixed settle time, captures the selected unit's result and returns it on a valid/ready response channel.
- Sits between the ALU front end and the bank of enable-gated combinational units.

---
 rtl/alu_op_sequencer_pkg.sv | 22 ++
 rtl/alu_op_sequencer_if.sv | 38 +++
 rtl/alu_op_decoder.sv | 31 +++
 rtl/alu_op_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode encodings, unit count and sequencer state type for the ALU
// operation sequencer and its enable decoder.
package alu_pkg;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_NOT_A  = 3'd3;
    localparam logic [2:0] OP_ADD    = 3'd4;
    localparam logic [2:0] OP_SUB    = 3'd5;
    localparam logic [2:0] OP_PASS_A = 3'd6;
    localparam logic [2:0] OP_PASS_B = 3'd7;

    localparam int NUM_UNITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, unit-enable and response signals between the ALU front end, the
// sequencer and the bank of enable-gated functional units.
interface alu_op_sequencer_if
    import alu_pkg::*;
#(
    parameter int W = 4
);

    logic                   req_valid;
    logic                   req_ready;
    logic [2:0]             req_op;
    logic [W-1:0]           req_a;
    logic [W-1:0]           req_b;

    logic [NUM_UNITS-1:0]   unit_en;
    logic [W-1:0]           unit_a;
    logic [W-1:0]           unit_b;
    logic [NUM_UNITS*W-1:0] unit_result;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [W-1:0]           rsp_data;
    logic                   rsp_zero;
    logic [2:0]             rsp_op;

    // Sequencer side
    modport master (
        input  req_valid, req_op, req_a, req_b, unit_result, rsp_ready,
        output req_ready, unit_en, unit_a, unit_b, rsp_valid, rsp_data, rsp_zero, rsp_op
    );

    // Front end plus unit bank side
    modport slave (
        output req_valid, req_op, req_a, req_b, unit_result, rsp_ready,
        input  req_ready, unit_en, unit_a, unit_b, rsp_valid, rsp_data, rsp_zero, rsp_op
    );

endinterface

// File: rtl/alu_op_decoder.sv
// Opcode to one-hot unit enable; i_en low forces all units off. Also intended
// for the microcode path, so it stays free of sequencer state.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [2:0]           i_op,
    input  logic                 i_en,
    output logic [NUM_UNITS-1:0] o_onehot
);

    // One-hot decode gated by the enable
    always_comb begin
        o_onehot = 8'b0000_0000;
        if (i_en) begin
            case (i_op)
                OP_AND:    o_onehot = 8'b0000_0001;
                OP_OR:     o_onehot = 8'b0000_0010;
                OP_XOR:    o_onehot = 8'b0000_0100;
                OP_NOT_A:  o_onehot = 8'b0000_1000;
                OP_ADD:    o_onehot = 8'b0001_0000;
                OP_SUB:    o_onehot = 8'b0010_0000;
                OP_PASS_A: o_onehot = 8'b0100_0000;
                OP_PASS_B: o_onehot = 8'b1000_0000;
                default:   o_onehot = 8'b0000_0000;
            endcase
        end else begin
            o_onehot = 8'b0000_0000;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one ALU request, holds the matching unit enabled for SETTLE_CYCLES
// cycles, samples that unit's result and presents it until taken.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int W             = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.master bus
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("alu_op_sequencer: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    seq_state_t           r_state;
    seq_state_t           w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [2:0]           r_op_q;
    logic [2:0]           w_op_nxt;
    logic [W-1:0]         r_unit_a;
    logic [W-1:0]         r_unit_b;
    logic [W-1:0]         w_a_nxt;
    logic [W-1:0]         w_b_nxt;
    logic [NUM_UNITS-1:0] r_unit_en;
    logic [NUM_UNITS-1:0] w_unit_en_nxt;
    logic                 w_drive_nxt;
    logic                 w_accept;
    logic                 w_capture;
    logic [W-1:0]         w_sel_result;
    logic [W-1:0]         r_rsp_data;
    logic                 r_rsp_zero;
    logic [2:0]           r_rsp_op;

    assign w_accept     = bus.req_valid && bus.req_ready;
    // Only the enabled unit's slice is read, so X on idle units cannot leak.
    assign w_sel_result = bus.unit_result[r_op_q*W +: W];
    assign w_drive_nxt  = (w_state_nxt == DRIVE);

    // Next-state, operand latch and settle counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op_q;
        w_a_nxt     = r_unit_a;
        w_b_nxt     = r_unit_b;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = DRIVE;
                    w_cnt_nxt   = CW'(SETTLE_CYCLES - 1);
                    w_op_nxt    = bus.req_op;
                    w_a_nxt     = bus.req_a;
                    w_b_nxt     = bus.req_b;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DRIVE: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Enable is decoded from the next state so the registered copy lines up
    // exactly with the DRIVE cycles.
    alu_op_decoder u_decoder (
        .i_op     (w_op_nxt),
        .i_en     (w_drive_nxt),
        .o_onehot (w_unit_en_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: operands, enables and captured response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= {CW{1'b0}};
            r_op_q     <= 3'd0;
            r_unit_a   <= {W{1'b0}};
            r_unit_b   <= {W{1'b0}};
            r_unit_en  <= 8'b0000_0000;
            r_rsp_data <= {W{1'b0}};
            r_rsp_zero <= 1'b1;
            r_rsp_op   <= 3'd0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_op_q    <= w_op_nxt;
            r_unit_a  <= w_a_nxt;
            r_unit_b  <= w_b_nxt;
            r_unit_en <= w_unit_en_nxt;
            if (w_capture) begin
                r_rsp_data <= w_sel_result;
                r_rsp_zero <= (w_sel_result == {W{1'b0}});
                r_rsp_op   <= r_op_q;
            end
        end
    end

    assign bus.req_ready = (r_state == IDLE) && !reset;
    assign bus.rsp_valid = (r_state == DONE);
    assign bus.unit_en   = r_unit_en;
    assign bus.unit_a    = r_unit_a;
    assign bus.unit_b    = r_unit_b;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.rsp_op    = r_rsp_op;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: three instances with settle times 1, 3
// and 4 driving a behavioural unit bank that outputs X when disabled.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1;
    logic rst3;
    logic rst4;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_on   = 1'b0;

    alu_op_sequencer_if #(.W(4)) if1 ();
    alu_op_sequencer_if #(.W(4)) if3 ();
    alu_op_sequencer_if #(.W(4)) if4 ();

    alu_op_sequencer #(.W(4), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(rst1), .bus(if1.master));
    alu_op_sequencer #(.W(4), .SETTLE_CYCLES(3)) dut3 (.clk(clk), .reset(rst3), .bus(if3.master));
    alu_op_sequencer #(.W(4), .SETTLE_CYCLES(4)) dut4 (.clk(clk), .reset(rst4), .bus(if4.master));

    function automatic logic [3:0] unit_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~a;
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return a;
            3'd7:    return b;
            default: return 4'h0;
        endcase
    endfunction

    always_comb begin
        if1.unit_result = {32{1'bx}};
        for (int k = 0; k < 8; k++)
            if (if1.unit_en[k]) if1.unit_result[k*4 +: 4] = unit_fn(3'(k), if1.unit_a, if1.unit_b);
    end
    always_comb begin
        if3.unit_result = {32{1'bx}};
        for (int k = 0; k < 8; k++)
            if (if3.unit_en[k]) if3.unit_result[k*4 +: 4] = unit_fn(3'(k), if3.unit_a, if3.unit_b);
    end
    always_comb begin
        if4.unit_result = {32{1'bx}};
        for (int k = 0; k < 8; k++)
            if (if4.unit_en[k]) if4.unit_result[k*4 +: 4] = unit_fn(3'(k), if4.unit_a, if4.unit_b);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Enables must never be multi-hot on any instance
    always @(negedge clk) begin
        if (mon_on) begin
            n_checks++;
            if (!$onehot0(if1.unit_en) || !$onehot0(if3.unit_en) || !$onehot0(if4.unit_en)) begin
                n_errors++;
                $display("FAIL onehot: en1=%b en3=%b en4=%b expected one-hot or zero",
                         if1.unit_en, if3.unit_en, if4.unit_en);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_data;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int k;
        int en_cnt;

        vecs[0]  = '{3'd0, 4'hC, 4'hA, 4'h8, 1'b0};
        vecs[1]  = '{3'd0, 4'h6, 4'h3, 4'h2, 1'b0};
        vecs[2]  = '{3'd1, 4'h6, 4'h3, 4'h7, 1'b0};
        vecs[3]  = '{3'd2, 4'h6, 4'h3, 4'h5, 1'b0};
        vecs[4]  = '{3'd3, 4'h6, 4'h3, 4'h9, 1'b0};
        vecs[5]  = '{3'd4, 4'h6, 4'h3, 4'h9, 1'b0};
        vecs[6]  = '{3'd5, 4'h6, 4'h3, 4'h3, 1'b0};
        vecs[7]  = '{3'd6, 4'h6, 4'h3, 4'h6, 1'b0};
        vecs[8]  = '{3'd7, 4'h6, 4'h3, 4'h3, 1'b0};
        vecs[9]  = '{3'd4, 4'hF, 4'h1, 4'h0, 1'b1};
        vecs[10] = '{3'd5, 4'h3, 4'h6, 4'hD, 1'b0};
        vecs[11] = '{3'd2, 4'h5, 4'h5, 4'h0, 1'b1};

        if1.req_valid = 1'b0; if1.req_op = 3'd0; if1.req_a = 4'h0; if1.req_b = 4'h0; if1.rsp_ready = 1'b1;
        if3.req_valid = 1'b0; if3.req_op = 3'd0; if3.req_a = 4'h0; if3.req_b = 4'h0; if3.rsp_ready = 1'b1;
        if4.req_valid = 1'b0; if4.req_op = 3'd0; if4.req_a = 4'h0; if4.req_b = 4'h0; if4.rsp_ready = 1'b1;
        rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;

        // Reset held for two cycles, then released
        tick;
        chk("rst_ready_c1", 32'(if1.req_ready), 32'd0);
        tick;
        chk("rst_ready_c2", 32'(if1.req_ready), 32'd0);
        chk("rst_ready_s3", 32'(if3.req_ready), 32'd0);
        rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
        #1;
        mon_on = 1'b1;
        chk("idle_ready",   32'(if1.req_ready), 32'd1);
        chk("idle_en",      32'(if1.unit_en),   32'd0);
        chk("idle_valid",   32'(if1.rsp_valid), 32'd0);
        chk("idle_data",    32'(if1.rsp_data),  32'd0);
        chk("idle_zero",    32'(if1.rsp_zero),  32'd1);
        chk("idle_op",      32'(if1.rsp_op),    32'd0);

        // Back-to-back table with req_valid held high and rsp_ready high
        for (int i = 0; i < 12; i++) begin
            if1.req_valid = 1'b1;
            if1.req_op = vecs[i].op; if1.req_a = vecs[i].a; if1.req_b = vecs[i].b;
            chk("tbl_ready", 32'(if1.req_ready), 32'd1);
            tick;
            chk("tbl_drive_en",    32'(if1.unit_en),   32'd1 << vecs[i].op);
            chk("tbl_drive_ready", 32'(if1.req_ready), 32'd0);
            chk("tbl_drive_valid", 32'(if1.rsp_valid), 32'd0);
            if (i < 11) begin
                if1.req_op = vecs[i+1].op; if1.req_a = vecs[i+1].a; if1.req_b = vecs[i+1].b;
            end else begin
                if1.req_valid = 1'b0;
            end
            tick;
            chk("tbl_done_valid", 32'(if1.rsp_valid), 32'd1);
            chk("tbl_done_en",    32'(if1.unit_en),   32'd0);
            chk("tbl_done_ready", 32'(if1.req_ready), 32'd0);
            chk("tbl_data",       32'(if1.rsp_data),  32'(vecs[i].exp_data));
            chk("tbl_zero",       32'(if1.rsp_zero),  32'(vecs[i].exp_zero));
            chk("tbl_op",         32'(if1.rsp_op),    32'(vecs[i].op));
            tick;
        end

        // Operand change one cycle after accept must not affect the result
        if1.req_valid = 1'b1; if1.req_op = 3'd6; if1.req_a = 4'h6; if1.req_b = 4'h3;
        tick;
        chk("cap_unit_a", 32'(if1.unit_a),  32'h6);
        chk("cap_en",     32'(if1.unit_en), 32'h40);
        if1.req_valid = 1'b0; if1.req_a = 4'hF;
        tick;
        chk("cap_data", 32'(if1.rsp_data), 32'h6);
        chk("cap_op",   32'(if1.rsp_op),   32'd6);
        tick;
        chk("cap_idle", 32'(if1.rsp_valid), 32'd0);

        // S=3: ADD 2+3 with rsp_ready high
        if3.req_valid = 1'b1; if3.req_op = 3'd4; if3.req_a = 4'h2; if3.req_b = 4'h3;
        tick;
        if3.req_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("s3_add_en",    32'(if3.unit_en),   32'h10);
            chk("s3_add_valid", 32'(if3.rsp_valid), 32'd0);
            tick;
        end
        chk("s3_add_done", 32'(if3.rsp_valid), 32'd1);
        chk("s3_add_data", 32'(if3.rsp_data),  32'h5);
        chk("s3_add_zero", 32'(if3.rsp_zero),  32'd0);
        tick;

        // S=3: XOR to zero with five stall cycles
        if3.rsp_ready = 1'b0;
        if3.req_valid = 1'b1; if3.req_op = 3'd2; if3.req_a = 4'hF; if3.req_b = 4'hF;
        tick;
        if3.req_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("s3_xor_en", 32'(if3.unit_en), 32'h04);
            tick;
        end
        for (int j = 0; j < 5; j++) begin
            chk("stall_valid", 32'(if3.rsp_valid), 32'd1);
            chk("stall_en",    32'(if3.unit_en),   32'd0);
            chk("stall_data",  32'(if3.rsp_data),  32'd0);
            chk("stall_zero",  32'(if3.rsp_zero),  32'd1);
            chk("stall_op",    32'(if3.rsp_op),    32'd2);
            if (j < 4) tick;
        end
        if3.rsp_ready = 1'b1;
        tick;
        chk("stall_release_valid", 32'(if3.rsp_valid), 32'd0);
        chk("stall_release_ready", 32'(if3.req_ready), 32'd1);

        // S=4: reset on the second DRIVE cycle abandons the operation
        if4.req_valid = 1'b1; if4.req_op = 3'd4; if4.req_a = 4'h5; if4.req_b = 4'h2;
        tick;
        if4.req_valid = 1'b0;
        chk("s4_drive1_en", 32'(if4.unit_en), 32'h10);
        tick;
        chk("s4_drive2_en", 32'(if4.unit_en), 32'h10);
        rst4 = 1'b1;
        tick;
        chk("s4_rst_en",    32'(if4.unit_en),   32'd0);
        chk("s4_rst_valid", 32'(if4.rsp_valid), 32'd0);
        chk("s4_rst_ready", 32'(if4.req_ready), 32'd0);
        rst4 = 1'b0;
        #1;
        for (int j = 0; j < 8; j++) begin
            chk("s4_no_rsp", 32'(if4.rsp_valid), 32'd0);
            tick;
        end
        chk("s4_idle_ready", 32'(if4.req_ready), 32'd1);

        // S=4: subsequent SUB completes with full settle time
        if4.req_valid = 1'b1; if4.req_op = 3'd5; if4.req_a = 4'h5; if4.req_b = 4'h2;
        tick;
        if4.req_valid = 1'b0;
        en_cnt = 0;
        for (k = 0; k < 20; k++) begin
            if (if4.rsp_valid) break;
            if (if4.unit_en == 8'h20) en_cnt++;
            tick;
        end
        chk("s4_rsp_timeout", 32'(if4.rsp_valid), 32'd1);
        chk("s4_latency",     32'(k),             32'd4);
        chk("s4_en_cycles",   32'(en_cnt),        32'd4);
        chk("s4_data",        32'(if4.rsp_data),  32'h3);
        chk("s4_zero",        32'(if4.rsp_zero),  32'd0);
        chk("s4_op",          32'(if4.rsp_op),    32'd5);
        tick;
        chk("s4_back_idle", 32'(if4.req_ready), 32'd1);

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
